// File: rtl/jogo_pkg.sv
// Shared constants for the tic-tac-toe move controller: FSM state codes,
// winner codes, full-board mask and the eight win-line masks.
package jogo_pkg;

  typedef enum logic [2:0] {
    E_INICIAL  = 3'd0,
    E_ESPERA   = 3'd1,
    E_VALIDA   = 3'd2,
    E_REGISTRA = 3'd3,
    E_VERIFICA = 3'd4,
    E_TROCA    = 3'd5,
    E_FIM      = 3'd6
  } estado_e;

  localparam logic [1:0] V_NENHUM = 2'b00;
  localparam logic [1:0] V_X      = 2'b01;
  localparam logic [1:0] V_O      = 2'b10;
  localparam logic [1:0] V_EMPATE = 2'b11;

  localparam logic [8:0] TABULEIRO_CHEIO = 9'h1FF;

  // Bit i of a mask is cell i: rows, columns, then the two diagonals.
  localparam logic [7:0][8:0] LINHAS = {
    9'h054,  // {2,4,6}
    9'h111,  // {0,4,8}
    9'h124,  // {2,5,8}
    9'h092,  // {1,4,7}
    9'h049,  // {0,3,6}
    9'h1C0,  // {6,7,8}
    9'h038,  // {3,4,5}
    9'h007   // {0,1,2}
  };

endpackage

// File: rtl/controlador_jogadas_if.sv
// Move-request / board-status bundle between the input decoder, the move
// controller and the display logic. The timeout strobe exists only when
// JOGADA_TIMEOUT_EN is defined.
interface controlador_jogadas_if;
  logic       iniciar;
  logic       jogada;
  logic [3:0] posicao;
  logic       pronto;
  logic       vez;
  logic [8:0] tab_x;
  logic [8:0] tab_o;
  logic       jogada_invalida;
  logic       fim_jogo;
  logic [1:0] vencedor;
  logic [2:0] db_estado;
`ifdef JOGADA_TIMEOUT_EN
  logic       timeout;
`endif

  modport master (
    output iniciar, jogada, posicao,
    input  pronto, vez, tab_x, tab_o, jogada_invalida, fim_jogo, vencedor, db_estado
`ifdef JOGADA_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  iniciar, jogada, posicao,
    output pronto, vez, tab_x, tab_o, jogada_invalida, fim_jogo, vencedor, db_estado
`ifdef JOGADA_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/controlador_jogadas_detector_vitoria.sv
// Combinational win detector: flags a 9-bit mark register that covers any
// of the eight tic-tac-toe lines.
module detector_vitoria
  import jogo_pkg::*;
(
  input  logic [8:0] marcas,
  output logic       vitoria
);

  // OR over the masked-AND check of every line
  always_comb begin
    vitoria = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((marcas & LINHAS[i]) == LINHAS[i]) vitoria = 1'b1;
    end
  end

endmodule

// File: rtl/controlador_jogadas.sv
// Tic-tac-toe move controller: accepts one move at a time, validates it
// against occupancy, writes it to the current player's board, then checks
// for a win or draw and passes the turn.
// Optional macro JOGADA_TIMEOUT_EN: an idle move timeout in ESPERA passes
// the turn and pulses the timeout output.
module controlador_jogadas
  import jogo_pkg::*;
#(
  parameter bit          JOGADOR_INICIAL = 1'b0,
  parameter int unsigned TIMEOUT_CICLOS  = 5000
) (
  input logic                   clock,
  input logic                   clear,
  controlador_jogadas_if.slave  bus
);

  estado_e    estado_q, estado_d;
  logic [8:0] tab_x_q, tab_x_d;
  logic [8:0] tab_o_q, tab_o_d;
  logic [3:0] pos_q, pos_d;
  logic       vez_q, vez_d;
  logic [1:0] vencedor_q, vencedor_d;
  logic [8:0] ocupado;
  logic [8:0] celula;
  logic       invalida;
  logic       vitoria;

`ifdef JOGADA_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CICLOS - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign ocupado  = tab_x_q | tab_o_q;
  // One-hot of the latched cell; all zero for out-of-range positions
  assign celula   = 9'(1) << pos_q;
  assign invalida = (pos_q > 4'd8) || (|(ocupado & celula));

  detector_vitoria u_detector (
    .marcas  (vez_q ? tab_o_q : tab_x_q),
    .vitoria (vitoria)
  );

  // State and board registers, cleared asynchronously
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      estado_q   <= E_INICIAL;
      tab_x_q    <= '0;
      tab_o_q    <= '0;
      pos_q      <= '0;
      vez_q      <= JOGADOR_INICIAL;
      vencedor_q <= V_NENHUM;
`ifdef JOGADA_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      tab_x_q    <= tab_x_d;
      tab_o_q    <= tab_o_d;
      pos_q      <= pos_d;
      vez_q      <= vez_d;
      vencedor_q <= vencedor_d;
`ifdef JOGADA_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state and register updates; iniciar overrides every transition
  always_comb begin
    estado_d   = estado_q;
    tab_x_d    = tab_x_q;
    tab_o_d    = tab_o_q;
    pos_d      = pos_q;
    vez_d      = vez_q;
    vencedor_d = vencedor_q;
`ifdef JOGADA_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif
    if (bus.iniciar) begin
      estado_d   = E_ESPERA;
      tab_x_d    = '0;
      tab_o_d    = '0;
      vez_d      = JOGADOR_INICIAL;
      vencedor_d = V_NENHUM;
    end else begin
      unique case (estado_q)
        E_INICIAL: ;
        E_ESPERA: begin
          if (bus.jogada) begin
            pos_d    = bus.posicao;
            estado_d = E_VALIDA;
          end
`ifdef JOGADA_TIMEOUT_EN
          else if (cnt_q == CntMax) begin
            estado_d  = E_TROCA;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        E_VALIDA:   estado_d = invalida ? E_ESPERA : E_REGISTRA;
        E_REGISTRA: begin
          if (vez_q) tab_o_d = tab_o_q | celula;
          else       tab_x_d = tab_x_q | celula;
          estado_d = E_VERIFICA;
        end
        E_VERIFICA: begin
          // A completed line wins even when it also fills the board
          if (vitoria) begin
            vencedor_d = vez_q ? V_O : V_X;
            estado_d   = E_FIM;
          end else if (ocupado == TABULEIRO_CHEIO) begin
            vencedor_d = V_EMPATE;
            estado_d   = E_FIM;
          end else begin
            estado_d = E_TROCA;
          end
        end
        E_TROCA: begin
          vez_d    = ~vez_q;
          estado_d = E_ESPERA;
        end
        E_FIM:   ;
        default: estado_d = E_INICIAL;
      endcase
    end
  end

  // State-decoded status outputs
  always_comb begin
    bus.pronto          = (estado_q == E_ESPERA);
    bus.fim_jogo        = (estado_q == E_FIM);
    bus.jogada_invalida = (estado_q == E_VALIDA) && invalida;
    bus.db_estado       = estado_q;
    bus.vez             = vez_q;
    bus.tab_x           = tab_x_q;
    bus.tab_o           = tab_o_q;
    bus.vencedor        = vencedor_q;
`ifdef JOGADA_TIMEOUT_EN
    bus.timeout         = timeout_q;
`endif
  end

endmodule

// File: tb/tb_controlador_jogadas.sv
// Directed bench for controlador_jogadas: reset, a won game, invalid moves,
// a drawn game, mid-move clear, iniciar/jogada collision and (with
// JOGADA_TIMEOUT_EN) the idle timeout.
module tb_controlador_jogadas;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  controlador_jogadas_if bus ();

  controlador_jogadas #(
    .JOGADOR_INICIAL (1'b0),
    .TIMEOUT_CICLOS  (8)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Submit one move, then count jogada_invalida pulses until the FSM is
  // back in ESPERA or in FIM.
  task automatic jogar(input logic [3:0] p, output int n_inv);
    int w;
    n_inv = 0;
    w = 0;
    while (!bus.pronto && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("pronto_antes", 32'(bus.pronto), 32'd1);
    bus.jogada  = 1'b1;
    bus.posicao = p;
    @(negedge clock);
    bus.jogada  = 1'b0;
    w = 0;
    while (w < 10) begin
      if (bus.jogada_invalida) n_inv++;
      if (bus.pronto || bus.fim_jogo) break;
      @(negedge clock);
      w++;
    end
    check("retorno", 32'(bus.pronto | bus.fim_jogo), 32'd1);
  endtask

  task automatic reiniciar();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pronto"}, 32'(bus.pronto), 32'd0);
    check({tag, "_vez"}, 32'(bus.vez), 32'd0);
    check({tag, "_tabs"}, {14'd0, bus.tab_x, bus.tab_o}, 32'd0);
    check({tag, "_venc"}, 32'(bus.vencedor), 32'd0);
    check({tag, "_fim_inv"}, {30'd0, bus.fim_jogo, bus.jogada_invalida}, 32'd0);
    check({tag, "_estado"}, 32'(bus.db_estado), 32'd0);
  endtask

  logic [3:0] seq_vit [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
  logic [3:0] seq_emp [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

  initial begin
    int inv;
    int pulsos;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.posicao = '0;
    repeat (2) @(negedge clock);
    check_reset("reset");
    clear = 1'b0;
    @(negedge clock);
    check("inicial_ocioso", 32'(bus.db_estado), 32'd0);

    // Start: ready, X to move, empty boards
    reiniciar();
    check("ini_pronto", 32'(bus.pronto), 32'd1);
    check("ini_vez", 32'(bus.vez), 32'd0);
    check("ini_tabs", {14'd0, bus.tab_x, bus.tab_o}, 32'd0);
    check("ini_estado", 32'(bus.db_estado), 32'd1);

    // X wins on the top row
    foreach (seq_vit[i]) begin
      jogar(seq_vit[i], inv);
      check("vit_valida", 32'(inv), 32'd0);
    end
    check("vit_tab_x", 32'(bus.tab_x), 32'h007);
    check("vit_tab_o", 32'(bus.tab_o), 32'h018);
    check("vit_venc", 32'(bus.vencedor), 32'd1);
    check("vit_fim", 32'(bus.fim_jogo), 32'd1);
    bus.jogada  = 1'b1;
    bus.posicao = 4'd8;
    repeat (4) @(negedge clock);
    bus.jogada  = 1'b0;
    check("fim_ignora_tab", {14'd0, bus.tab_x, bus.tab_o}, {14'd0, 9'h007, 9'h018});
    check("fim_mantem", 32'(bus.db_estado), 32'd6);

    // Occupied cell and out-of-range cell are both rejected
    reiniciar();
    jogar(4'd4, inv);
    check("x4_vez", 32'(bus.vez), 32'd1);
    jogar(4'd4, inv);
    check("ocupada_pulso", 32'(inv), 32'd1);
    check("ocupada_tab_o", 32'(bus.tab_o), 32'h000);
    check("ocupada_vez", 32'(bus.vez), 32'd1);
    jogar(4'd12, inv);
    check("fora_pulso", 32'(inv), 32'd1);
    check("fora_tabs", {14'd0, bus.tab_x, bus.tab_o}, {14'd0, 9'h010, 9'h000});

    // Full board without a line: draw
    reiniciar();
    foreach (seq_emp[i]) jogar(seq_emp[i], inv);
    check("emp_tab_x", 32'(bus.tab_x), 32'h18D);
    check("emp_tab_o", 32'(bus.tab_o), 32'h072);
    check("emp_venc", 32'(bus.vencedor), 32'd3);
    check("emp_fim", 32'(bus.fim_jogo), 32'd1);

    // clear while REGISTRA: nothing survives
    reiniciar();
    bus.jogada  = 1'b1;
    bus.posicao = 4'd5;
    @(negedge clock);
    bus.jogada  = 1'b0;
    check("pre_valida", 32'(bus.db_estado), 32'd2);
    @(negedge clock);
    check("pre_registra", 32'(bus.db_estado), 32'd3);
    clear = 1'b1;
    #1;
    check_reset("clear_meio");
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("pos_clear_tabs", {14'd0, bus.tab_x, bus.tab_o}, 32'd0);

    // iniciar and jogada together: restart wins
    reiniciar();
    jogar(4'd2, inv);
    check("col_pre_x", 32'(bus.tab_x), 32'h004);
    bus.iniciar = 1'b1;
    bus.jogada  = 1'b1;
    bus.posicao = 4'd0;
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    check("col_estado", 32'(bus.db_estado), 32'd1);
    check("col_vez", 32'(bus.vez), 32'd0);
    repeat (3) @(negedge clock);
    check("col_tabs", {14'd0, bus.tab_x, bus.tab_o}, 32'd0);

`ifdef JOGADA_TIMEOUT_EN
    // Idle for 8 cycles in ESPERA: turn passes, board untouched
    reiniciar();
    pulsos = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.timeout) pulsos++;
      @(negedge clock);
    end
    check("to_pulsos", 32'(pulsos), 32'd1);
    check("to_vez", 32'(bus.vez), 32'd1);
    check("to_tabs", {14'd0, bus.tab_x, bus.tab_o}, 32'd0);
`else
    pulsos = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
